// File: rtl/spin_pkg.sv
// Shared types and defaults for the spin-speed selector and motor ramp.
// State codes, wash-mode codes, default speed table and per-mode levels.
package spin_pkg;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    RAMP_UP   = 2'd1,
    HOLD      = 2'd2,
    RAMP_DOWN = 2'd3
  } state_t;

  typedef enum logic [3:0] {
    COTTON    = 4'd0,
    SYNTHETIC = 4'd1,
    WOOL      = 4'd2,
    DELICATE  = 4'd3,
    QUICK     = 4'd4,
    RINSE     = 4'd5,
    SPIN      = 4'd6,
    COLOURS   = 4'd7
  } wash_mode_t;

  localparam logic [43:0] DEF_SPEED_TABLE = {
    11'd1400, 11'd1200, 11'd800, 11'd400
  };

  localparam logic [15:0] DEF_MODE_DEFAULTS = {
    2'd3, 2'd1, 2'd0, 2'd3,
    2'd1, 2'd2, 2'd3, 2'd3
  };

  function automatic int idx_w(input int n);
    return (n > 2) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/spin_speed_ramp_ctrl_if.sv
// Front-panel / motor-driver bundle for the spin controller.
// master drives the requests, slave returns level and setpoint.
interface spin_speed_ramp_ctrl_if #(
  parameter int MODE_W  = 4,
  parameter int IDX_W   = 2,
  parameter int SPEED_W = 11
);
  logic [MODE_W-1:0]  wash_mode;
  logic               mode_load;
  logic               increment;
  logic               decrement;
  logic               spin_start;
  logic               spin_stop;
  logic [IDX_W-1:0]   level_index;
  logic [SPEED_W-1:0] selected_spin_speed;
  logic [SPEED_W-1:0] motor_speed;
  logic               spinning;
  logic               at_speed;

  modport master (
    output wash_mode, mode_load,
    output increment, decrement,
    output spin_start, spin_stop,
    input  level_index, selected_spin_speed,
    input  motor_speed, spinning, at_speed
  );

  modport slave (
    input  wash_mode, mode_load,
    input  increment, decrement,
    input  spin_start, spin_stop,
    output level_index, selected_spin_speed,
    output motor_speed, spinning, at_speed
  );
endinterface

// File: rtl/spin_ramp_gen.sv
// Ramp FSM: steps the motor setpoint toward a latched target
// every RAMP_DIV cycles, holds, then ramps back to zero.
module spin_ramp_gen
  import spin_pkg::*;
#(
  parameter int SPEED_W   = 11,
  parameter int RAMP_STEP = 100,
  parameter int RAMP_DIV  = 4
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic               start,
  input  logic               stop,
  input  logic [SPEED_W-1:0] target_in,
  output logic [SPEED_W-1:0] motor_speed,
  output logic               spinning,
  output logic               at_speed
);

  localparam int PW = (RAMP_DIV > 1) ? $clog2(RAMP_DIV) : 1;
  localparam logic [PW-1:0] LAST = PW'(RAMP_DIV - 1);
  localparam logic [SPEED_W:0] STEP = (SPEED_W+1)'(RAMP_STEP);

  state_t             state, next_state;
  logic [PW-1:0]      presc;
  logic [SPEED_W-1:0] target;
  logic [SPEED_W-1:0] up_speed, down_speed;
  logic [SPEED_W:0]   sum;
  logic               tick, up_done, down_done;

  // One extra bit keeps the climb from wrapping past full scale
  always_comb begin
    tick       = (presc == LAST);
    sum        = {1'b0, motor_speed} + STEP;
    up_done    = (sum >= {1'b0, target});
    up_speed   = up_done ? target : sum[SPEED_W-1:0];
    down_done  = ({1'b0, motor_speed} <= STEP);
    down_speed = down_done ? '0
                 : motor_speed - STEP[SPEED_W-1:0];
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state <= IDLE;
    else          state <= next_state;
  end

  always_comb begin
    next_state = state;
    unique case (state)
      IDLE:
        if (start && !stop && target_in != '0)
          next_state = RAMP_UP;
      RAMP_UP:
        if (stop)                 next_state = RAMP_DOWN;
        else if (tick && up_done) next_state = HOLD;
      HOLD:
        if (stop) next_state = RAMP_DOWN;
      RAMP_DOWN:
        if (tick && down_done) next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  always_comb begin
    spinning = (state != IDLE);
    at_speed = (state == HOLD);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      presc       <= '0;
      target      <= '0;
      motor_speed <= '0;
    end else if (state == IDLE && next_state == RAMP_UP) begin
      presc  <= '0;
      target <= target_in;
    end else if (state != RAMP_DOWN && next_state == RAMP_DOWN) begin
      presc <= '0;
    end else if (state == RAMP_UP || state == RAMP_DOWN) begin
      presc <= tick ? '0 : presc + 1'b1;
      if (tick)
        motor_speed <= (state == RAMP_UP) ? up_speed : down_speed;
    end
  end

endmodule

// File: rtl/spin_speed_ramp_ctrl.sv
// Spin-speed level selection per wash mode with button edge detect,
// feeding the motor ramp generator.
module spin_speed_ramp_ctrl
  import spin_pkg::*;
#(
  parameter int NUM_LEVELS = 4,
  parameter int SPEED_W    = 11,
  parameter int MODE_W     = 4,
  parameter int NUM_MODES  = 8,
  parameter logic [NUM_LEVELS*SPEED_W-1:0] SPEED_TABLE =
    DEF_SPEED_TABLE,
  parameter logic [NUM_MODES*idx_w(NUM_LEVELS)-1:0] MODE_DEFAULTS =
    DEF_MODE_DEFAULTS,
  parameter bit WRAP_EN   = 1'b1,
  parameter int RAMP_STEP = 100,
  parameter int RAMP_DIV  = 4
) (
  input logic                  clk,
  input logic                  reset_n,
  spin_speed_ramp_ctrl_if.slave bus
);

  localparam int IDX_W = idx_w(NUM_LEVELS);
  localparam logic [IDX_W-1:0] TOP = IDX_W'(NUM_LEVELS - 1);

  logic [IDX_W-1:0]   level, def_level, next_level;
  logic [SPEED_W-1:0] sel, table_speed;
  logic [MODE_W-1:0]  mode_prev;
  logic               inc_prev, dec_prev, load_pending;
  logic               inc_edge, dec_edge, load, spinning;

  always_comb begin
    def_level = '0;
    for (int m = 0; m < NUM_MODES; m++)
      if (bus.wash_mode == MODE_W'(m))
        def_level = MODE_DEFAULTS[m*IDX_W +: IDX_W];
  end

  always_comb begin
    table_speed = SPEED_TABLE[0 +: SPEED_W];
    for (int i = 0; i < NUM_LEVELS; i++)
      if (level == IDX_W'(i))
        table_speed = SPEED_TABLE[i*SPEED_W +: SPEED_W];
  end

  // Requests arriving while spinning are dropped, not deferred
  always_comb begin
    inc_edge   = bus.increment & ~inc_prev;
    dec_edge   = bus.decrement & ~dec_prev;
    load       = load_pending | bus.mode_load
               | (bus.wash_mode != mode_prev);
    next_level = level;
    if (!spinning) begin
      if (load)
        next_level = def_level;
      else if (inc_edge && dec_edge)
        next_level = level;
      else if (inc_edge)
        next_level = (level == TOP)
                   ? (WRAP_EN ? '0 : level) : level + 1'b1;
      else if (dec_edge)
        next_level = (level == '0)
                   ? (WRAP_EN ? TOP : level) : level - 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      level        <= '0;
      sel          <= SPEED_TABLE[0 +: SPEED_W];
      inc_prev     <= 1'b0;
      dec_prev     <= 1'b0;
      mode_prev    <= '0;
      load_pending <= 1'b1;
    end else begin
      level        <= next_level;
      sel          <= table_speed;
      inc_prev     <= bus.increment;
      dec_prev     <= bus.decrement;
      mode_prev    <= bus.wash_mode;
      load_pending <= 1'b0;
    end
  end

  spin_ramp_gen #(
    .SPEED_W   (SPEED_W),
    .RAMP_STEP (RAMP_STEP),
    .RAMP_DIV  (RAMP_DIV)
  ) u_ramp (
    .clk         (clk),
    .reset_n     (reset_n),
    .start       (bus.spin_start),
    .stop        (bus.spin_stop),
    .target_in   (sel),
    .motor_speed (bus.motor_speed),
    .spinning    (spinning),
    .at_speed    (bus.at_speed)
  );

  assign bus.level_index         = level;
  assign bus.selected_spin_speed = sel;
  assign bus.spinning            = spinning;

endmodule

// File: tb/tb_spin_speed_ramp_ctrl.sv
// Bench for spin_speed_ramp_ctrl: a wrapping/step-100 instance and a
// saturating/step-300 instance share stimulus against a rule model.
module tb_spin_speed_ramp_ctrl;

  logic clk = 1'b0;
  logic reset_n;
  always #5 clk = ~clk;

  logic [3:0] wash_mode;
  logic mode_load, increment, decrement;
  logic spin_start, spin_stop;

  int vectors = 0;
  int miscompares = 0;
  int lvl [2];
  int step_of [2] = '{100, 300};
  bit wrap_of [2] = '{1'b1, 1'b0};

  spin_speed_ramp_ctrl_if #(
    .MODE_W(4), .IDX_W(2), .SPEED_W(11)) ifa ();
  spin_speed_ramp_ctrl_if #(
    .MODE_W(4), .IDX_W(2), .SPEED_W(11)) ifb ();

  assign ifa.wash_mode  = wash_mode;
  assign ifa.mode_load  = mode_load;
  assign ifa.increment  = increment;
  assign ifa.decrement  = decrement;
  assign ifa.spin_start = spin_start;
  assign ifa.spin_stop  = spin_stop;
  assign ifb.wash_mode  = wash_mode;
  assign ifb.mode_load  = mode_load;
  assign ifb.increment  = increment;
  assign ifb.decrement  = decrement;
  assign ifb.spin_start = spin_start;
  assign ifb.spin_stop  = spin_stop;

  spin_speed_ramp_ctrl dut_a (
    .clk(clk), .reset_n(reset_n), .bus(ifa));

  spin_speed_ramp_ctrl #(
    .WRAP_EN(1'b0), .RAMP_STEP(300)
  ) dut_b (
    .clk(clk), .reset_n(reset_n), .bus(ifb));

  logic [1:0]  o_lvl [2];
  logic [10:0] o_sel [2];
  logic [10:0] o_mot [2];
  logic        o_spin [2];
  logic        o_at [2];

  assign o_lvl[0]  = ifa.level_index;
  assign o_sel[0]  = ifa.selected_spin_speed;
  assign o_mot[0]  = ifa.motor_speed;
  assign o_spin[0] = ifa.spinning;
  assign o_at[0]   = ifa.at_speed;
  assign o_lvl[1]  = ifb.level_index;
  assign o_sel[1]  = ifb.selected_spin_speed;
  assign o_mot[1]  = ifb.motor_speed;
  assign o_spin[1] = ifb.spinning;
  assign o_at[1]   = ifb.at_speed;

  function automatic int def_lvl(input int m);
    int md [8];
    md = '{3, 3, 2, 1, 3, 0, 1, 3};
    return (m < 8) ? md[m] : 0;
  endfunction

  function automatic int spd(input int l);
    int t [4];
    t = '{400, 800, 1200, 1400};
    return t[l];
  endfunction

  function automatic int step_lvl(input int l, input bit inc,
                                  input bit dec, input bit wrap);
    if (inc && dec) return l;
    if (inc) return (l == 3) ? (wrap ? 0 : 3) : l + 1;
    if (dec) return (l == 0) ? (wrap ? 3 : 0) : l - 1;
    return l;
  endfunction

  function automatic int ticks_to(input int tgt, input int st);
    return ((tgt + st - 1) / st) * 4;
  endfunction

  // Drive one level request for a cycle while idle, update model
  task automatic drive_levels(input int m, input bit ld,
                              input bit inc, input bit dec);
    bit load;
    load = ld || (m != int'(wash_mode));
    for (int d = 0; d < 2; d++)
      lvl[d] = load ? def_lvl(m)
                    : step_lvl(lvl[d], inc, dec, wrap_of[d]);
    wash_mode = 4'(m);
    mode_load = ld;
    increment = inc;
    decrement = dec;
    @(negedge clk);
    mode_load = 1'b0;
    increment = 1'b0;
    decrement = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_reset();
    logic [25:0] got, want;
    reset_n = 1'b0;
    wash_mode = 4'd3;
    mode_load = 1'b0;
    increment = 1'b0;
    decrement = 1'b0;
    spin_start = 1'b0;
    spin_stop = 1'b0;
    repeat (2) @(negedge clk);
    for (int d = 0; d < 2; d++) begin
      got  = {o_lvl[d], o_sel[d], o_mot[d], o_spin[d], o_at[d]};
      want = {2'd0, 11'd400, 11'd0, 1'b0, 1'b0};
      vectors++;
      if (got !== want) begin
        miscompares++;
        $display("FAIL reset_state dut%0d got %h want %h",
                 d, got, want);
      end
    end
    reset_n = 1'b1;
    @(negedge clk);
    for (int d = 0; d < 2; d++) begin
      lvl[d] = def_lvl(3);
      vectors++;
      if ({o_lvl[d], o_sel[d]} !== {2'(lvl[d]), 11'd400}) begin
        miscompares++;
        $display("FAIL reset_load dut%0d got %0d/%0d want %0d/400",
                 d, o_lvl[d], o_sel[d], lvl[d]);
      end
    end
    @(negedge clk);
    for (int d = 0; d < 2; d++) begin
      vectors++;
      if (o_sel[d] !== 11'(spd(lvl[d]))) begin
        miscompares++;
        $display("FAIL reset_speed dut%0d got %0d want %0d",
                 d, o_sel[d], spd(lvl[d]));
      end
    end
  endtask

  task automatic test_levels();
    int dm [4]   = '{0, 0, 0, 0};
    bit dld [4]  = '{1, 0, 0, 0};
    bit dinc [4] = '{0, 1, 1, 0};
    bit ddec [4] = '{0, 0, 1, 1};
    int m;
    bit ld, inc, dec;
    logic [12:0] got, want;
    for (int i = 0; i < 28; i++) begin
      if (i < 4) begin
        m = dm[i]; ld = dld[i]; inc = dinc[i]; dec = ddec[i];
      end else begin
        m = ($urandom_range(0, 3) == 0) ? $urandom_range(0, 15)
                                         : int'(wash_mode);
        ld  = ($urandom_range(0, 4) == 0);
        inc = 1'($urandom_range(0, 1));
        dec = 1'($urandom_range(0, 1));
      end
      drive_levels(m, ld, inc, dec);
      for (int d = 0; d < 2; d++) begin
        got  = {o_lvl[d], o_sel[d]};
        want = {2'(lvl[d]), 11'(spd(lvl[d]))};
        vectors++;
        if (got !== want) begin
          miscompares++;
          $display("FAIL level_%0d dut%0d got %0d/%0d want %0d/%0d",
                   i, d, o_lvl[d], o_sel[d], lvl[d], spd(lvl[d]));
        end
      end
    end
  endtask

  task automatic test_ramp(input int m, input bit both);
    int tgt [2];
    int kmax, v;
    logic [12:0] got, want;
    logic [13:0] hgot, hwant;
    drive_levels(m, 1'b1, 1'b0, 1'b0);
    for (int d = 0; d < 2; d++) tgt[d] = spd(lvl[d]);
    spin_start = 1'b1;
    spin_stop  = 1'b1;
    @(negedge clk);
    spin_start = 1'b0;
    spin_stop  = 1'b0;
    for (int d = 0; d < 2; d++) begin
      vectors++;
      if (o_spin[d] !== 1'b0) begin
        miscompares++;
        $display("FAIL idle_start_stop dut%0d got %b want 0",
                 d, o_spin[d]);
      end
    end
    spin_start = 1'b1;
    @(negedge clk);
    spin_start = 1'b0;
    kmax = 0;
    for (int d = 0; d < 2; d++)
      if (ticks_to(tgt[d], step_of[d]) > kmax)
        kmax = ticks_to(tgt[d], step_of[d]);
    for (int k = 1; k <= kmax + 2; k++) begin
      @(negedge clk);
      for (int d = 0; d < 2; d++) begin
        v = step_of[d] * (k / 4);
        want = {11'((v < tgt[d]) ? v : tgt[d]), 1'b1, v >= tgt[d]};
        got  = {o_mot[d], o_spin[d], o_at[d]};
        vectors++;
        if (got !== want) begin
          miscompares++;
          $display("FAIL ramp_up dut%0d k%0d got %h want %h",
                   d, k, got, want);
        end
      end
    end
    increment = 1'b1;
    wash_mode = 4'((m + 1) % 8);
    @(negedge clk);
    increment = 1'b0;
    repeat (2) @(negedge clk);
    for (int d = 0; d < 2; d++) begin
      hgot  = {o_lvl[d], o_mot[d], o_at[d]};
      hwant = {2'(lvl[d]), 11'(tgt[d]), 1'b1};
      vectors++;
      if (hgot !== hwant) begin
        miscompares++;
        $display("FAIL hold_lock dut%0d got %h want %h",
                 d, hgot, hwant);
      end
    end
    spin_stop  = 1'b1;
    spin_start = both;
    @(negedge clk);
    spin_stop  = 1'b0;
    spin_start = 1'b0;
    for (int k = 1; k <= kmax + 2; k++) begin
      @(negedge clk);
      for (int d = 0; d < 2; d++) begin
        v = tgt[d] - step_of[d] * (k / 4);
        if (v < 0) v = 0;
        want = {11'(v), v > 0, 1'b0};
        got  = {o_mot[d], o_spin[d], o_at[d]};
        vectors++;
        if (got !== want) begin
          miscompares++;
          $display("FAIL ramp_down dut%0d k%0d got %h want %h",
                   d, k, got, want);
        end
      end
    end
    for (int d = 0; d < 2; d++) begin
      vectors++;
      if (o_lvl[d] !== 2'(lvl[d])) begin
        miscompares++;
        $display("FAIL no_reload dut%0d got %0d want %0d",
                 d, o_lvl[d], lvl[d]);
      end
    end
  endtask

  task automatic test_reset_mid_ramp();
    logic [14:0] got;
    drive_levels(0, 1'b1, 1'b0, 1'b0);
    spin_start = 1'b1;
    @(negedge clk);
    spin_start = 1'b0;
    repeat (28) @(negedge clk);
    vectors++;
    if (o_mot[0] !== 11'd700) begin
      miscompares++;
      $display("FAIL mid_ramp_speed got %0d want 700", o_mot[0]);
    end
    wash_mode = 4'd3;
    #2;
    reset_n = 1'b0;
    #1;
    for (int d = 0; d < 2; d++) begin
      got = {o_lvl[d], o_mot[d], o_spin[d], o_at[d]};
      vectors++;
      if (got !== 15'd0) begin
        miscompares++;
        $display("FAIL async_reset dut%0d got %h want 0", d, got);
      end
    end
    @(negedge clk);
    reset_n = 1'b1;
    for (int d = 0; d < 2; d++) lvl[d] = def_lvl(3);
    repeat (2) @(negedge clk);
    for (int d = 0; d < 2; d++) begin
      vectors++;
      if ({o_lvl[d], o_sel[d]} !== {2'(lvl[d]), 11'd800}) begin
        miscompares++;
        $display("FAIL reload_after_reset dut%0d got %0d/%0d want %0d/800",
                 d, o_lvl[d], o_sel[d], lvl[d]);
      end
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    test_reset();
    test_levels();
    for (int i = 0; i < 4; i++)
      test_ramp((i == 0) ? 0 : (i == 1) ? 5 : $urandom_range(0, 7),
                1'(i % 2));
    test_reset_mid_ramp();
    $display("== %0d vectors applied, %0d miscompares ==",
             vectors, miscompares);
    $finish;
  end

endmodule
